// File: rtl/link_probe_pkg.sv
// ----------------------------------------------------------------------------
// link_probe_pkg : shared types and constants for the UART link prober.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package link_probe_pkg;

    localparam int PROBE_W = 8;
    localparam logic [PROBE_W-1:0] REPLY_OFFSET = 8'h01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_RX = 3'd2,
        CHECK   = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic logic [PROBE_W-1:0] sat_inc(input logic [PROBE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/probe_seq_fsm.sv
// ----------------------------------------------------------------------------
// probe_seq_fsm : probe sequencing, reply timeout and pass/fail scoring.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module probe_seq_fsm
    import link_probe_pkg::*;
#(
    parameter int                 TIMEOUT_CYC = 1_000_000,
    parameter logic [PROBE_W-1:0] FIRST_PROBE = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [PROBE_W-1:0] count_req_i,
    input  logic               tx_busy_i,
    input  logic               rx_valid_i,
    input  logic [PROBE_W-1:0] rx_data_i,
    output logic               send_o,
    output logic [PROBE_W-1:0] data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [PROBE_W-1:0] pass_cnt_o,
    output logic [PROBE_W-1:0] fail_cnt_o,
    output logic               timeout_seen_o,
    output logic [PROBE_W-1:0] last_rcvd_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [PROBE_W-1:0] remaining_q, remaining_d;
    logic [PROBE_W-1:0] probe_q, probe_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [PROBE_W-1:0] pass_q, pass_d;
    logic [PROBE_W-1:0] fail_q, fail_d;
    logic               to_q, to_d;
    logic [PROBE_W-1:0] last_q, last_d;
    logic               vld_q1, vld_q2;
    logic               reply_evt;
    logic [PROBE_W-1:0] expected;

    // Edge-detect so a held-high valid can only ever score one reply.
    assign reply_evt = vld_q1 & ~vld_q2;
    assign expected  = probe_q + REPLY_OFFSET;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q1 <= 1'b0;
            vld_q2 <= 1'b0;
        end else begin
            vld_q1 <= rx_valid_i;
            vld_q2 <= vld_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            probe_q     <= '0;
            timer_q     <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            to_q        <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            probe_q     <= probe_d;
            timer_q     <= timer_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            to_q        <= to_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        probe_d     = probe_q;
        timer_d     = timer_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        to_d        = to_q;
        last_d      = last_q;
        send_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    remaining_d = count_req_i;
                    probe_d     = FIRST_PROBE;
                    pass_d      = '0;
                    fail_d      = '0;
                    to_d        = 1'b0;
                    state_d     = (count_req_i == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                send_o  = 1'b1;
                timer_d = TW'(TIMEOUT_CYC - 1);
                state_d = WAIT_RX;
            end
            WAIT_RX: begin
                // A reply arriving on the expiry cycle still wins.
                if (reply_evt) begin
                    last_d  = rx_data_i;
                    state_d = CHECK;
                end else if (timer_q == '0) begin
                    fail_d  = sat_inc(fail_q);
                    to_d    = 1'b1;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            CHECK: begin
                if (last_q == expected) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                end
                state_d = GAP;
            end
            GAP: begin
                if (!tx_busy_i) begin
                    remaining_d = remaining_q - 1'b1;
                    probe_d     = probe_q + 1'b1;
                    state_d     = (remaining_q == 8'd1) ? DONE : SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o         = probe_q;
    assign busy_o         = (state_q != IDLE) && (state_q != DONE);
    assign done_o         = (state_q == DONE);
    assign pass_cnt_o     = pass_q;
    assign fail_cnt_o     = fail_q;
    assign timeout_seen_o = to_q;
    assign last_rcvd_o    = last_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 byte receiver; valid_o pulses one cycle per good frame.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Two cycles of the centre offset are already spent in the synchronizer.
    localparam int HALF = (CLKS_PER_BIT / 2 > 2) ? CLKS_PER_BIT / 2 - 2 : 0;

    logic          rx_meta_q, rx_sync_q;
    logic          busy_q, valid_q;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q, data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!busy_q) begin
                if (!rx_sync_q) begin
                    busy_q    <= 1'b1;
                    clk_cnt_q <= CW'(HALF);
                    bit_cnt_q <= '0;
                end
            end else if (clk_cnt_q != '0) begin
                clk_cnt_q <= clk_cnt_q - CW'(1);
            end else begin
                clk_cnt_q <= CW'(CLKS_PER_BIT - 1);
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    if (rx_sync_q) begin
                        busy_q <= 1'b0;
                    end
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q <= {rx_sync_q, shift_q[7:1]};
                end else begin
                    busy_q <= 1'b0;
                    if (rx_sync_q) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx : 8N1 byte transmitter, line idles high.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [CW-1:0] clk_cnt_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '1;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else if (!busy_q) begin
            if (send_i) begin
                shift_q   <= {1'b1, data_i, 1'b0};
                bit_cnt_q <= '0;
                clk_cnt_q <= '0;
                busy_q    <= 1'b1;
            end
        end else if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q <= '0;
            shift_q   <= {1'b1, shift_q[9:1]};
            if (bit_cnt_q == 4'd9) begin
                busy_q <= 1'b0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
        end
    end

    assign tx_o   = shift_q[0];
    assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/uart_link_prober.sv
// ----------------------------------------------------------------------------
// uart_link_prober : sends probe bytes, expects probe+1 echoes, counts results.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_link_prober
    import link_probe_pkg::*;
#(
    parameter int                 TIMEOUT_CYC  = 1_000_000,
    parameter logic [PROBE_W-1:0] FIRST_PROBE  = 8'h00,
    parameter int                 CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PROBE_W-1:0] count_req,
    input  logic               rx,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic [PROBE_W-1:0] pass_cnt,
    output logic [PROBE_W-1:0] fail_cnt,
    output logic               timeout_seen,
    output logic [PROBE_W-1:0] last_rcvd
);

    logic               w_send;
    logic [PROBE_W-1:0] w_tx_data;
    logic               w_tx_busy;
    logic               w_rx_valid;
    logic [PROBE_W-1:0] w_rx_data;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .send_i (w_send),
        .data_i (w_tx_data),
        .tx_o   (tx),
        .busy_o (w_tx_busy)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_i    (rx),
        .data_o  (w_rx_data),
        .valid_o (w_rx_valid)
    );

    probe_seq_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIRST_PROBE (FIRST_PROBE)
    ) u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .count_req_i    (count_req),
        .tx_busy_i      (w_tx_busy),
        .rx_valid_i     (w_rx_valid),
        .rx_data_i      (w_rx_data),
        .send_o         (w_send),
        .data_o         (w_tx_data),
        .busy_o         (busy),
        .done_o         (done),
        .pass_cnt_o     (pass_cnt),
        .fail_cnt_o     (fail_cnt),
        .timeout_seen_o (timeout_seen),
        .last_rcvd_o    (last_rcvd)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_link_prober.sv
// ----------------------------------------------------------------------------
// tb_uart_link_prober : two probers sharing one modelled echo responder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_link_prober;

    localparam int CPB      = 4;
    localparam int TO       = 1000;
    localparam int M_OK     = 0;
    localparam int M_PLUS2  = 1;
    localparam int M_SILENT = 2;

    typedef struct {
        int sel;
        int first;
        int cnt;
        int mode;
        int exp_pass;
        int exp_fail;
        int exp_to;
        int exp_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] cnt0 = 8'h00, cnt1 = 8'h00;
    logic       rx = 1'b1;
    logic       tx0, tx1, busy0, busy1, done0, done1, to0, to1;
    logic [7:0] pass0, pass1, fail0, fail1, last0, last1;

    int         checks = 0;
    int         failures = 0;
    int         resp_mode = M_OK;
    int         resp_sel = 0;
    int         nsent = 0;
    int         dcnt0 = 0, dcnt1 = 0;
    logic [7:0] sent_q[$];

    wire       tx_mon = (resp_sel == 1) ? tx1 : tx0;
    wire [7:0] m_pass = (resp_sel == 1) ? pass1 : pass0;
    wire [7:0] m_fail = (resp_sel == 1) ? fail1 : fail0;
    wire [7:0] m_last = (resp_sel == 1) ? last1 : last0;
    wire       m_to   = (resp_sel == 1) ? to1 : to0;

    uart_link_prober #(.TIMEOUT_CYC(TO), .FIRST_PROBE(8'h00), .CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .count_req(cnt0), .rx(rx), .tx(tx0),
        .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
        .timeout_seen(to0), .last_rcvd(last0));

    uart_link_prober #(.TIMEOUT_CYC(TO), .FIRST_PROBE(8'hFE), .CLKS_PER_BIT(CPB)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .count_req(cnt1), .rx(rx), .tx(tx1),
        .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
        .timeout_seen(to1), .last_rcvd(last1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done0) dcnt0 <= dcnt0 + 1;
        if (done1) dcnt1 <= dcnt1 + 1;
    end

    // Echo responder: decodes a frame on the selected tx, replies byte+1.
    initial begin : responder
        logic [7:0] b;
        logic [7:0] r;
        forever begin
            @(negedge tx_mon);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx_mon;
            end
            repeat (CPB) @(negedge clk);
            sent_q.push_back(b);
            nsent++;
            if (resp_mode != M_SILENT) begin
                r = b + 8'h01;
                if (resp_mode == M_PLUS2 && nsent == 2) r = b + 8'h02;
                repeat (3) @(negedge clk);
                rx = 1'b0;
                repeat (CPB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx = r[i];
                    repeat (CPB) @(negedge clk);
                end
                rx = 1'b1;
                repeat (CPB) @(negedge clk);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int sel, input logic [7:0] cnt);
        @(negedge clk);
        if (sel == 1) begin
            start1 = 1'b1;
            cnt1   = cnt;
        end else begin
            start0 = 1'b1;
            cnt0   = cnt;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((sel == 1) ? done1 : done0) seen = 1'b1;
        end
        chk("done_within_budget", int'(seen), 1);
    endtask

    task automatic prep(input int sel, input int mode);
        repeat (10) @(negedge clk);
        resp_sel  = sel;
        resp_mode = mode;
        sent_q.delete();
        nsent = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        prep(v.sel, v.mode);
        d0 = (v.sel == 1) ? dcnt1 : dcnt0;
        pulse_start(v.sel, v.cnt[7:0]);
        wait_done(v.sel, 20000);
        repeat (2) @(negedge clk);
        chk("pass_cnt", int'(m_pass), v.exp_pass);
        chk("fail_cnt", int'(m_fail), v.exp_fail);
        chk("timeout_seen", int'(m_to), v.exp_to);
        chk("last_rcvd", int'(m_last), v.exp_last);
        chk("done_pulses", ((v.sel == 1) ? dcnt1 : dcnt0) - d0, 1);
        chk("bytes_sent", sent_q.size(), v.cnt);
        for (int i = 0; i < sent_q.size() && i < v.cnt; i++)
            chk("probe_byte", int'(sent_q[i]), (v.first + i) & 255);
    endtask

    initial begin : main
        vec_t vt[5];
        int   d0;
        int   c;
        bit   txlow;
        logic [7:0] f0;

        vt[0] = '{0, 8'h00, 4, M_OK,     4, 0, 0, 8'h04};
        vt[1] = '{1, 8'hFE, 3, M_OK,     3, 0, 0, 8'h01};
        vt[2] = '{0, 8'h00, 3, M_PLUS2,  2, 1, 0, 8'h03};
        vt[3] = '{0, 8'h00, 2, M_SILENT, 0, 2, 1, 8'h03};
        vt[4] = '{1, 8'hFE, 1, M_OK,     1, 0, 0, 8'hFF};

        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_fail", int'(fail0), 0);
        chk("rst_timeout", int'(to0), 0);
        chk("rst_last", int'(last0), 0);
        chk("rst_tx_dut1", int'(tx1), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(vt[k]);

        // Silent responder: each fail lands TO cycles after its send.
        prep(0, M_SILENT);
        pulse_start(0, 8'd2);
        for (int p = 0; p < 2; p++) begin
            c = 0;
            while (tx0 && c < 5000) begin
                @(negedge clk);
                c++;
            end
            chk("tx_start_bit_seen", int'(c < 5000), 1);
            f0 = fail0;
            c  = 0;
            while (fail0 == f0 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            chk("timeout_latency", c, TO);
        end
        wait_done(0, 5000);
        chk("timeout_fail_cnt", int'(fail0), 2);
        chk("timeout_sticky", int'(to0), 1);

        // Zero-length run: immediate done, no transmission, counters cleared.
        prep(0, M_OK);
        d0 = dcnt0;
        start0 = 1'b1;
        cnt0   = 8'd0;
        @(negedge clk);
        start0 = 1'b0;
        chk("zero_done", int'(done0), 1);
        chk("zero_busy", int'(busy0), 0);
        txlow = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!tx0) txlow = 1'b1;
        end
        chk("zero_tx_idle", int'(txlow), 0);
        chk("zero_done_pulses", dcnt0 - d0, 1);
        chk("zero_fail_cleared", int'(fail0), 0);
        chk("zero_timeout_cleared", int'(to0), 0);

        // Bad second reply: last_rcvd shows probe+2 right after that check.
        prep(0, M_PLUS2);
        pulse_start(0, 8'd3);
        c = 0;
        while (fail0 == 8'd0 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("plus2_last_rcvd", int'(last0), 8'h03);
        chk("plus2_pass_so_far", int'(pass0), 1);
        wait_done(0, 5000);
        repeat (2) @(negedge clk);
        chk("plus2_pass", int'(pass0), 2);
        chk("plus2_fail", int'(fail0), 1);

        // Reset while waiting for a reply, then a clean run ignoring a re-start.
        prep(0, M_SILENT);
        pulse_start(0, 8'd3);
        repeat (60) @(negedge clk);
        chk("mid_busy", int'(busy0), 1);
        d0 = dcnt0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx0), 1);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_done", int'(done0), 0);
        chk("mid_rst_pass", int'(pass0), 0);
        chk("mid_rst_fail", int'(fail0), 0);
        chk("mid_rst_timeout", int'(to0), 0);
        chk("mid_rst_last", int'(last0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_rst_no_done", dcnt0 - d0, 0);
        prep(0, M_OK);
        d0 = dcnt0;
        pulse_start(0, 8'd2);
        repeat (5) @(negedge clk);
        pulse_start(0, 8'd5);
        wait_done(0, 5000);
        repeat (2) @(negedge clk);
        chk("rerun_pass", int'(pass0), 2);
        chk("rerun_fail", int'(fail0), 0);
        chk("rerun_bytes", sent_q.size(), 2);
        chk("rerun_done_pulses", dcnt0 - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
